// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // Defaults for a 27 MHz board oscillator.
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 27000;
  localparam int DEF_STABLE_CYCLES = 2700;
  localparam int DEF_MAX_RETRIES   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Sample the async input twice to let metastability settle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses PLL reset, waits for and qualifies lock,
// then releases the downstream reset. Bounded retries end in FAIL.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   PLL_RST   | PLL reset held high for RST_CYCLES
//   WAIT_LOCK | PLL reset released, waiting up to LOCK_TIMEOUT for lock
//   STABLE    | lock seen, must hold for STABLE_CYCLES consecutive cycles
//   RUN       | lock qualified, downstream reset released
//   FAIL      | retries exhausted, PLL held in reset until retry_req
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             pll_lock,
  input  logic                             retry_req,
  output logic                             pll_reset,
  output logic                             user_rst_n,
  output logic                             pll_ok,
  output logic                             pll_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [7:0]                       loss_cnt
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam int RET_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RET_W-1:0] MAX_RET  = RET_W'(MAX_RETRIES);

  pll_state_e       r_state;
  pll_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [RET_W-1:0] r_retry_cnt;
  logic [RET_W-1:0] w_retry_nxt;
  logic [7:0]       r_loss_cnt;
  logic [7:0]       w_loss_nxt;
  logic             w_lock_s;

  logic             r_pll_reset;
  logic             r_user_rst_n;
  logic             r_pll_ok;
  logic             r_pll_fail;

  sync_2ff u_lock_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (pll_lock),
    .o_q     (w_lock_s)
  );

  // Next-state, shared counter and retry/loss bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_retry_nxt = r_retry_cnt;
    w_loss_nxt  = r_loss_cnt;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (w_lock_s) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_cnt_nxt = '0;
          if (r_retry_cnt < MAX_RET) begin
            w_retry_nxt = r_retry_cnt + 1'b1;
            w_state_nxt = PLL_RST;
          end else begin
            w_state_nxt = FAIL;
          end
        end
      end
      STABLE: begin
        // A dropout restarts the lock wait but does not consume a retry.
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_state_nxt = PLL_RST;
          if (r_loss_cnt != 8'hFF) begin
            w_loss_nxt = r_loss_cnt + 8'd1;
          end
        end
      end
      FAIL: begin
        w_cnt_nxt = '0;
        if (retry_req) begin
          w_retry_nxt = '0;
          w_state_nxt = PLL_RST;
        end
      end
      default: begin
        w_state_nxt = PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_state_nxt == RUN) begin
      w_retry_nxt = '0;
    end
  end

  // State, counter and status registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= PLL_RST;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_loss_cnt  <= w_loss_nxt;
    end
  end

  // Outputs decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pll_reset  <= 1'b1;
      r_user_rst_n <= 1'b0;
      r_pll_ok     <= 1'b0;
      r_pll_fail   <= 1'b0;
    end else begin
      r_pll_reset  <= (w_state_nxt == PLL_RST) || (w_state_nxt == FAIL);
      r_user_rst_n <= (w_state_nxt == RUN);
      r_pll_ok     <= (w_state_nxt == RUN);
      r_pll_fail   <= (w_state_nxt == FAIL);
    end
  end

  assign pll_reset  = r_pll_reset;
  assign user_rst_n = r_user_rst_n;
  assign pll_ok     = r_pll_ok;
  assign pll_fail   = r_pll_fail;
  assign retry_cnt  = r_retry_cnt;
  assign loss_cnt   = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with a phase-level reference model.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_QUAL = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  localparam int SEL_URST = 0;
  localparam int SEL_FAIL = 1;
  localparam int SEL_PRST = 2;

  localparam logic [13:0] RST_OUTS = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00};

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_lock  = 1'b0;
  logic       retry_req = 1'b0;
  logic       pll_reset, user_rst_n, pll_ok, pll_fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [13:0] w_outs;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_lock   (pll_lock),
    .retry_req  (retry_req),
    .pll_reset  (pll_reset),
    .user_rst_n (user_rst_n),
    .pll_ok     (pll_ok),
    .pll_fail   (pll_fail),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  assign w_outs = {pll_reset, user_rst_n, pll_ok, pll_fail, retry_cnt, loss_cnt};

  always #5 sys_clk = ~sys_clk;

  int edge_cnt = 0;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          edge_no;
    logic [13:0] outs;
  } exp_t;

  typedef struct {
    int    edge_no;
    int    sel;
    bit    val;
    string name;
  } ms_t;

  exp_t exp_q[$];
  ms_t  ms_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   stim_err = 0;
  bit   done     = 1'b0;

  // Reference model: phase, cycles spent in phase, retries, losses, lock pipeline.
  int m_phase, m_t, m_ret, m_loss;
  bit m_s1, m_s2;

  function automatic void model_reset();
    m_phase = P_RST;
    m_t     = 0;
    m_ret   = 0;
    m_loss  = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
  endfunction

  function automatic void model_edge(input bit lk, input bit rq);
    bit ls;
    ls = m_s2;
    case (m_phase)
      P_RST: begin
        m_t++;
        if (m_t == RST_CYCLES) begin m_phase = P_WAIT; m_t = 0; end
      end
      P_WAIT: begin
        if (ls) begin
          m_phase = P_QUAL; m_t = 0;
        end else begin
          m_t++;
          if (m_t == LOCK_TIMEOUT) begin
            m_t = 0;
            if (m_ret < MAX_RETRIES) begin m_ret++; m_phase = P_RST; end
            else m_phase = P_FAIL;
          end
        end
      end
      P_QUAL: begin
        if (!ls) begin
          m_phase = P_WAIT; m_t = 0;
        end else begin
          m_t++;
          if (m_t == STABLE_CYCLES) begin m_phase = P_RUN; m_t = 0; end
        end
      end
      P_RUN: begin
        if (!ls) begin
          m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
          m_phase = P_RST;
          m_t     = 0;
        end
      end
      default: begin
        if (rq) begin m_ret = 0; m_phase = P_RST; m_t = 0; end
      end
    endcase
    if (m_phase == P_RUN) m_ret = 0;
    m_s2 = m_s1;
    m_s1 = lk;
  endfunction

  function automatic logic [13:0] model_outs();
    logic pr, ur, fl;
    pr = (m_phase == P_RST) || (m_phase == P_FAIL);
    ur = (m_phase == P_RUN);
    fl = (m_phase == P_FAIL);
    return {pr, ur, ur, fl, 2'(m_ret), 8'(m_loss)};
  endfunction

  function automatic void push_ms(input int e, input int s, input bit v, input string n);
    ms_t m;
    m.edge_no = e;
    m.sel     = s;
    m.val     = v;
    m.name    = n;
    ms_q.push_back(m);
  endfunction

  // Drive inputs for the next edge, queue the predicted outputs, advance one cycle.
  task automatic step(input bit lk, input bit rq);
    exp_t e;
    pll_lock  = lk;
    retry_req = rq;
    if (sys_rst_n) model_edge(lk, rq);
    e.edge_no = edge_cnt + 1;
    e.outs    = model_outs();
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_until(input int target, input bit lk);
    for (int i = 0; i < 200; i++) begin
      step(lk, 1'b0);
      if (m_phase == target) return;
    end
    stim_err++;
  endtask

  task automatic loss_once(input bit with_ms);
    if (with_ms) push_ms(edge_cnt + 3, SEL_URST, 1'b0, "loss_user_rst_fall");
    step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    run_until(P_RUN, 1'b1);
  endtask

  // Stimulus.
  initial begin : stim
    int base;
    int lvl;
    int len;
    int cyc;
    model_reset();
    repeat (3) step(1'b0, 1'b0);

    // Clean start.
    sys_rst_n = 1'b1;
    base = edge_cnt;
    push_ms(base + RST_CYCLES, SEL_PRST, 1'b0, "start_pll_reset_fall");
    repeat (RST_CYCLES + 5) step(1'b0, 1'b0);
    push_ms(edge_cnt + 2 + STABLE_CYCLES + 1, SEL_URST, 1'b1, "start_user_rst_rise");
    repeat (2 + STABLE_CYCLES + 3) step(1'b1, 1'b0);

    // Repeated lock loss in RUN, saturating the loss counter.
    for (int i = 0; i < 260; i++) loss_once(i < 3);

    // Lock bounce: into WAIT_LOCK, short lock, one-cycle drop, re-lock.
    repeat (RST_CYCLES + 4) step(1'b0, 1'b0);
    if (m_phase != P_WAIT) stim_err++;
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    push_ms(edge_cnt + 2 + STABLE_CYCLES + 1, SEL_URST, 1'b1, "bounce_user_rst_rise");
    repeat (2 + STABLE_CYCLES + 3) step(1'b1, 1'b0);

    // Async reset in the middle of STABLE.
    repeat (RST_CYCLES + 4) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    if (m_phase != P_QUAL) stim_err++;
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    repeat (2) step(1'b1, 1'b0);

    // Never lock: all retries exhausted, then FAIL.
    sys_rst_n = 1'b1;
    base = edge_cnt;
    push_ms(base + RST_CYCLES, SEL_PRST, 1'b0, "nolock_pll_reset_fall");
    push_ms(base + (MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT), SEL_FAIL, 1'b1, "nolock_fail_rise");
    repeat ((MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT) + 6) step(1'b0, 1'b0);

    // Recovery from FAIL.
    push_ms(edge_cnt + 1, SEL_FAIL, 1'b0, "recover_fail_clear");
    step(1'b0, 1'b1);
    repeat (RST_CYCLES) step(1'b0, 1'b0);
    push_ms(edge_cnt + 2 + STABLE_CYCLES + 1, SEL_URST, 1'b1, "recover_user_rst_rise");
    repeat (2 + STABLE_CYCLES + 3) step(1'b1, 1'b0);

    // Randomized lock behaviour with stray retry requests.
    cyc = 0;
    while (cyc < 2500) begin
      lvl = int'($urandom_range(0, 1));
      if (lvl == 1) len = int'($urandom_range(1, 40));
      else if ($urandom_range(0, 3) == 0) len = int'($urandom_range(60, 90));
      else len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) step(lvl[0], $urandom_range(0, 7) == 0);
      cyc += len;
    end

    repeat (2) step(1'b0, 1'b0);
    done = 1'b1;
  end

  // Monitor: compares DUT outputs against queued predictions and milestones.
  initial begin : monitor
    exp_t        e;
    ms_t         m;
    bit          prev_rst_n;
    logic [2:0]  prev_sig;
    logic [2:0]  cur_sig;
    prev_rst_n = 1'b0;
    prev_sig   = 3'b000;
    forever begin
      @(negedge sys_clk or negedge sys_rst_n);
      if (prev_rst_n && !sys_rst_n) begin
        #1;
        total++;
        if (w_outs !== RST_OUTS) begin
          bad++;
          $display("FAIL async_reset: got %h want %h", w_outs, RST_OUTS);
        end
      end else begin
        while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
          e = exp_q.pop_front();
          total++;
          if (e.edge_no != edge_cnt || w_outs !== e.outs) begin
            bad++;
            if (bad <= 30)
              $display("FAIL outputs edge %0d: got %h want %h (rst,urst_n,ok,fail,retry,loss)",
                       e.edge_no, w_outs, e.outs);
          end
        end
        cur_sig = {pll_reset, pll_fail, user_rst_n};
        while (ms_q.size() > 0 && ms_q[0].edge_no <= edge_cnt) begin
          m = ms_q.pop_front();
          total++;
          if (m.edge_no != edge_cnt || cur_sig[m.sel] !== m.val || prev_sig[m.sel] !== !m.val) begin
            bad++;
            $display("FAIL %s at edge %0d: got %b after %b, want %b after %b",
                     m.name, m.edge_no, cur_sig[m.sel], prev_sig[m.sel], m.val, !m.val);
          end
        end
        prev_sig = cur_sig;
      end
      prev_rst_n = sys_rst_n;
      if (done && exp_q.size() == 0) begin
        total++;
        if (ms_q.size() != 0) begin
          bad++;
          $display("FAIL milestones_left: got %0d pending want 0", ms_q.size());
        end
        total++;
        if (stim_err != 0) begin
          bad++;
          $display("FAIL phase_reach: got %0d missed targets want 0", stim_err);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion want completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
